// File: rtl/bcd_entry_reg.sv
// bcd_entry_reg
//
// Purpose:
//   Turns raw push-button presses into a calculator-style packed-BCD entry
//   register. Each button is synchronized, rising edges are detected, and the
//   accepted digits are shifted in from the right. The block also supports
//   backspace and clear. A short lockout after each accepted event rejects
//   crude contact bounce.
//
// Ports:
//   hz100      in   system clock; all state updates on its rising edge
//   reset      in   synchronous, active-high reset
//   dig_pb     in   raw digit buttons, bit i = digit i
//   bksp_pb    in   raw backspace button
//   clr_pb     in   raw clear button
//   value      out  packed BCD entry, digit 0 (least significant) in [3:0]
//   count      out  number of digits entered, 0..NDIG
//   full       out  count == NDIG
//   strobe     out  one-cycle pulse after each accepted event
//   last_digit out  most recently accepted digit code

module bcd_entry_reg #(
  parameter int NDIG    = 8,
  parameter int LOCKOUT = 3
) (
  input  logic                hz100,
  input  logic                reset,
  input  logic [9:0]          dig_pb,
  input  logic                bksp_pb,
  input  logic                clr_pb,
  output logic [4*NDIG-1:0]   value,
  output logic [3:0]          count,
  output logic                full,
  output logic                strobe,
  output logic [3:0]          last_digit
);

  localparam int              VW        = 4 * NDIG;
  localparam int              LW        = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
  localparam logic [LW-1:0]   LOCK_LOAD = LW'(LOCKOUT);
  localparam logic [3:0]      NDIG_C    = 4'(NDIG);

  // Button vector layout: [11] clear, [10] backspace, [9:0] digits.
  localparam int CLR_BIT  = 11;
  localparam int BKSP_BIT = 10;

  logic [11:0]   raw;
  logic [11:0]   s1_q, s1_d;
  logic [11:0]   s2_q, s2_d;
  logic [11:0]   s3_q, s3_d;
  logic [11:0]   edges;

  logic [VW-1:0] value_q, value_d;
  logic [3:0]    count_q, count_d;
  logic [3:0]    last_q, last_d;
  logic          strobe_q, strobe_d;
  logic [LW-1:0] lock_q, lock_d;

  logic          dig_hit;
  logic [3:0]    dig_sel;

  assign raw   = {clr_pb, bksp_pb, dig_pb};
  assign s1_d  = raw;
  assign s2_d  = s1_q;
  assign s3_d  = s2_q;
  assign edges = s2_q & ~s3_q;

  // Lowest-index digit edge wins; scanning downward lets the smallest index
  // overwrite any larger one found earlier.
  always_comb begin
    dig_hit = 1'b0;
    dig_sel = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (edges[i]) begin
        dig_hit = 1'b1;
        dig_sel = 4'(i);
      end
    end
  end

  // Only one event per cycle, clear > backspace > digit. Lower-priority
  // edges in the same cycle are simply dropped. Ignored events (backspace
  // when empty, digit when full) neither strobe nor load the lockout.
  always_comb begin
    value_d  = value_q;
    count_d  = count_q;
    last_d   = last_q;
    strobe_d = 1'b0;
    lock_d   = (lock_q != '0) ? lock_q - LW'(1) : lock_q;

    if (lock_q == '0) begin
      if (edges[CLR_BIT]) begin
        value_d  = '0;
        count_d  = 4'd0;
        strobe_d = 1'b1;
        lock_d   = LOCK_LOAD;
      end else if (edges[BKSP_BIT]) begin
        if (count_q != 4'd0) begin
          value_d  = value_q >> 4;
          count_d  = count_q - 4'd1;
          strobe_d = 1'b1;
          lock_d   = LOCK_LOAD;
        end
      end else if (dig_hit && (count_q < NDIG_C)) begin
        value_d  = (value_q << 4) | VW'(dig_sel);
        count_d  = count_q + 4'd1;
        last_d   = dig_sel;
        strobe_d = 1'b1;
        lock_d   = LOCK_LOAD;
      end
    end
  end

  // During reset the synchronizer keeps sampling the buttons and s3 is
  // loaded with the same value as s2, so a button held across reset looks
  // "already high" and produces no edge until it is released and re-pressed.
  always_ff @(posedge hz100) begin
    if (reset) begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s2_d;
      value_q  <= '0;
      count_q  <= 4'd0;
      last_q   <= 4'd0;
      strobe_q <= 1'b0;
      lock_q   <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      value_q  <= value_d;
      count_q  <= count_d;
      last_q   <= last_d;
      strobe_q <= strobe_d;
      lock_q   <= lock_d;
    end
  end

  assign value      = value_q;
  assign count      = count_q;
  assign full       = (count_q == NDIG_C);
  assign strobe     = strobe_q;
  assign last_digit = last_q;

endmodule

// File: tb/tb_bcd_entry_reg.sv
// tb_bcd_entry_reg
//
// Testbench for bcd_entry_reg (NDIG=8, LOCKOUT=3). Button presses are driven
// on the falling clock edge; each press that should be accepted pushes the
// expected register state onto a queue, and a monitor pops and compares an
// entry every time the DUT raises strobe.

module tb_bcd_entry_reg;

  logic        hz100;
  logic        reset;
  logic [11:0] rawBits;
  logic [31:0] value;
  logic [3:0]  count;
  logic        full;
  logic        strobe;
  logic [3:0]  last_digit;

  bcd_entry_reg #(.NDIG(8), .LOCKOUT(3)) dut (
    .hz100      (hz100),
    .reset      (reset),
    .dig_pb     (rawBits[9:0]),
    .bksp_pb    (rawBits[10]),
    .clr_pb     (rawBits[11]),
    .value      (value),
    .count      (count),
    .full       (full),
    .strobe     (strobe),
    .last_digit (last_digit)
  );

  // 10 ns clock
  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  typedef struct {
    string       tag;
    logic [31:0] value;
    logic [3:0]  count;
    logic        full;
    logic [3:0]  last;
    int          expCyc;
  } exp_t;

  exp_t        sbQueue[$];
  exp_t        popped;
  int          checkCount = 0;
  int          passCount  = 0;
  int          cyc        = 0;
  int          strobeSeen = 0;
  int          pushCount  = 0;
  bit          monitorOn  = 1'b0;

  logic [31:0] mValue;
  logic [3:0]  mCount;
  logic [3:0]  mLast;

  // Single comparison point: counts, and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Model updates, each pushing the state the DUT should show with its strobe.
  task automatic pushExp(input string tag);
    exp_t e;
    e.tag    = tag;
    e.value  = mValue;
    e.count  = mCount;
    e.full   = (mCount == 4'd8);
    e.last   = mLast;
    e.expCyc = -1;
    sbQueue.push_back(e);
    pushCount++;
  endtask

  task automatic expectDigit(input string tag, input logic [3:0] d);
    mValue = {mValue[27:0], d};
    mCount = mCount + 4'd1;
    mLast  = d;
    pushExp(tag);
  endtask

  task automatic expectBksp(input string tag);
    mValue = {4'h0, mValue[31:4]};
    mCount = mCount - 4'd1;
    pushExp(tag);
  endtask

  task automatic expectClear(input string tag);
    mValue = 32'h0;
    mCount = 4'd0;
    pushExp(tag);
  endtask

  // Drive a button pattern on the falling edge for 'hold' cycles, then release
  // for 'gap' cycles. With checkLat set, the most recently pushed expectation
  // must arrive exactly three rising edges after the drive point (s1, s2, event).
  task automatic applyStimulus(input logic [11:0] bits, input int hold, input int gap, input bit checkLat);
    @(negedge hz100);
    rawBits = bits;
    if (checkLat && sbQueue.size() > 0) sbQueue[sbQueue.size()-1].expCyc = cyc + 3;
    repeat (hold) @(negedge hz100);
    rawBits = 12'h000;
    repeat (gap) @(negedge hz100);
  endtask

  // Scoreboard monitor: samples 1 ns after each rising edge.
  always @(posedge hz100) begin
    #1;
    cyc++;
    if (monitorOn && strobe === 1'b1) begin
      strobeSeen++;
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_strobe", {31'h0, strobe}, 32'h0);
      end else begin
        popped = sbQueue.pop_front();
        checkOutput({popped.tag, "_value"}, value, popped.value);
        checkOutput({popped.tag, "_count"}, {28'h0, count}, {28'h0, popped.count});
        checkOutput({popped.tag, "_full"}, {31'h0, full}, {31'h0, popped.full});
        checkOutput({popped.tag, "_last"}, {28'h0, last_digit}, {28'h0, popped.last});
        if (popped.expCyc >= 0)
          checkOutput({popped.tag, "_latency"}, cyc, popped.expCyc);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    rawBits = 12'h000;
    mValue  = 32'h0;
    mCount  = 4'd0;
    mLast   = 4'd0;

    // Reset state
    repeat (3) @(posedge hz100);
    #1;
    checkOutput("reset_value", value, 32'h0);
    checkOutput("reset_count", {28'h0, count}, 32'h0);
    checkOutput("reset_full", {31'h0, full}, 32'h0);
    checkOutput("reset_strobe", {31'h0, strobe}, 32'h0);
    checkOutput("reset_last", {28'h0, last_digit}, 32'h0);
    @(negedge hz100);
    reset     = 1'b0;
    monitorOn = 1'b1;
    repeat (2) @(negedge hz100);

    // Digits 1, 2, 3 with latency check
    for (int d = 1; d <= 3; d++) begin
      expectDigit($sformatf("t1_dig%0d", d), 4'(d));
      applyStimulus(12'h001 << d, 5, 6, 1'b1);
    end
    checkOutput("t1_value", value, 32'h00000123);
    checkOutput("t1_count", {28'h0, count}, 32'd3);
    checkOutput("t1_strobes", strobeSeen, 32'd3);

    // Fill to 8 digits; the 9th press is ignored
    expectClear("t2_clr");
    applyStimulus(12'h800, 5, 6, 1'b0);
    for (int d = 1; d <= 8; d++) begin
      expectDigit($sformatf("t2_dig%0d", d), 4'(d));
      applyStimulus(12'h001 << d, 5, 6, 1'b0);
    end
    applyStimulus(12'h200, 5, 6, 1'b0);
    checkOutput("t2_value", value, 32'h12345678);
    checkOutput("t2_count", {28'h0, count}, 32'd8);
    checkOutput("t2_full", {31'h0, full}, 32'h1);
    checkOutput("t2_last", {28'h0, last_digit}, 32'd8);

    // Backspace, including one on an empty register
    expectClear("t3_clr");
    applyStimulus(12'h800, 5, 6, 1'b0);
    for (int d = 1; d <= 3; d++) begin
      expectDigit($sformatf("t3_dig%0d", d), 4'(d));
      applyStimulus(12'h001 << d, 5, 6, 1'b0);
    end
    expectBksp("t3_bk1");
    applyStimulus(12'h400, 5, 6, 1'b0);
    checkOutput("t3_value_after_bk1", value, 32'h12);
    expectBksp("t3_bk2");
    applyStimulus(12'h400, 5, 6, 1'b0);
    expectBksp("t3_bk3");
    applyStimulus(12'h400, 5, 6, 1'b0);
    applyStimulus(12'h400, 5, 6, 1'b0);
    checkOutput("t3_value", value, 32'h0);
    checkOutput("t3_count", {28'h0, count}, 32'd0);
    checkOutput("t3_last", {28'h0, last_digit}, 32'd3);

    // Same-cycle priority: clear beats digit, lowest digit wins
    expectDigit("t4_dig7", 4'd7);
    applyStimulus(12'h080, 5, 6, 1'b0);
    expectClear("t4_clr_vs_5");
    applyStimulus(12'h820, 5, 6, 1'b0);
    checkOutput("t4_value_clr", value, 32'h0);
    expectDigit("t4_dig2_vs_7", 4'd2);
    applyStimulus(12'h084, 5, 6, 1'b0);
    checkOutput("t4_value_dig", value, 32'h2);

    // Long hold gives one entry; a press inside lockout is lost
    expectClear("t5_clr");
    applyStimulus(12'h800, 5, 6, 1'b0);
    expectDigit("t5_dig4", 4'd4);
    @(negedge hz100);
    rawBits = 12'h010;
    repeat (3) @(negedge hz100);
    rawBits = 12'h050;
    repeat (3) @(negedge hz100);
    rawBits = 12'h010;
    repeat (44) @(negedge hz100);
    rawBits = 12'h000;
    repeat (6) @(negedge hz100);
    checkOutput("t5_value", value, 32'h4);
    checkOutput("t5_count", {28'h0, count}, 32'd1);

    // Reset while a digit is held
    expectDigit("t6_dig5", 4'd5);
    applyStimulus(12'h020, 5, 6, 1'b0);
    checkOutput("t6_value_pre", value, 32'h45);
    @(negedge hz100);
    rawBits = 12'h100;
    @(negedge hz100);
    reset = 1'b1;
    @(posedge hz100);
    #1;
    checkOutput("t6_rst_value", value, 32'h0);
    checkOutput("t6_rst_count", {28'h0, count}, 32'd0);
    checkOutput("t6_rst_full", {31'h0, full}, 32'h0);
    checkOutput("t6_rst_strobe", {31'h0, strobe}, 32'h0);
    checkOutput("t6_rst_last", {28'h0, last_digit}, 32'd0);
    mValue = 32'h0;
    mCount = 4'd0;
    mLast  = 4'd0;
    @(negedge hz100);
    reset = 1'b0;
    repeat (10) @(negedge hz100);
    rawBits = 12'h000;
    repeat (6) @(negedge hz100);
    checkOutput("t6_held_value", value, 32'h0);
    expectDigit("t6_dig8", 4'd8);
    applyStimulus(12'h100, 5, 6, 1'b0);
    checkOutput("t6_value", value, 32'h8);

    repeat (10) @(negedge hz100);
    checkOutput("sb_empty", sbQueue.size(), 32'd0);
    checkOutput("strobe_total", strobeSeen, pushCount);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
